// File: rtl/fft_layer_sequencer.sv
// Sequences scramble + radix-2 FFT layers over the shared RAM/ROM bus, with a drain gap per layer.
// Outputs decode from registered state only (one-cycle response to start/done); no backpressure, i_start is ignored while busy.
module fft_layer_sequencer #(
    parameter int NUM_LAYERS   = 4,
    parameter int SEL_SIZE     = $clog2(NUM_LAYERS),
    parameter int DRAIN_CYCLES = 3,
    parameter int TIMER_SIZE   = 10
) (
    input  logic                  i_CLK,
    input  logic                  i_RST,
    input  logic                  i_start,
    input  logic [NUM_LAYERS-1:0] i_layer_done,
    output logic [SEL_SIZE-1:0]   o_layer_sel,
    output logic [NUM_LAYERS-1:0] o_cs,
    output logic                  o_bus_grant,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [TIMER_SIZE-1:0] o_cycles
);

    localparam int                  CNT_W      = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
    localparam bit                  HAS_DRAIN  = (DRAIN_CYCLES > 0);
    localparam logic [SEL_SIZE-1:0] LAST_SEL   = SEL_SIZE'(NUM_LAYERS - 1);
    localparam logic [CNT_W-1:0]    DRAIN_LOAD = CNT_W'(DRAIN_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_FINISH
    } state_t;

    state_t                state_q, state_d;
    logic [SEL_SIZE-1:0]   sel_q, sel_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [TIMER_SIZE-1:0] cycles_q, cycles_d;
    logic [TIMER_SIZE-1:0] cycles_inc;
    logic                  layer_done;

    // Only the owning layer's flag matters; a stale flag from the previous index is masked by the new sel.
    assign layer_done = i_layer_done[sel_q];
    assign cycles_inc = (&cycles_q) ? cycles_q : cycles_q + 1'b1;

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state_q  <= S_IDLE;
            sel_q    <= '0;
            cnt_q    <= '0;
            cycles_q <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            cnt_q    <= cnt_d;
            cycles_q <= cycles_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        cnt_d    = cnt_q;
        cycles_d = cycles_q;
        unique case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d  = S_RUN;
                    sel_d    = '0;
                    cycles_d = '0;
                end
            end
            S_RUN: begin
                cycles_d = cycles_inc;
                if (layer_done) begin
                    if (HAS_DRAIN) begin
                        state_d = S_DRAIN;
                        cnt_d   = DRAIN_LOAD;
                    end else if (sel_q == LAST_SEL) begin
                        state_d = S_FINISH;
                    end else begin
                        sel_d = sel_q + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                cycles_d = cycles_inc;
                cnt_d    = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    if (sel_q == LAST_SEL) begin
                        state_d = S_FINISH;
                    end else begin
                        state_d = S_RUN;
                        sel_d   = sel_q + 1'b1;
                    end
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        o_layer_sel = sel_q;
        o_cycles    = cycles_q;
        o_bus_grant = (state_q == S_RUN);
        o_busy      = (state_q != S_IDLE);
        o_done      = (state_q == S_FINISH);
        o_cs        = '0;
        if (state_q == S_RUN) begin
            o_cs = NUM_LAYERS'(1) << sel_q;
        end
    end

endmodule

// File: tb/tb_fft_layer_sequencer.sv
// Bench for fft_layer_sequencer: nominal, spurious-done, abort, zero-drain and saturating-timer instances.
module tb_fft_layer_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;

    // Main instance: DRAIN_CYCLES=2, TIMER_SIZE=10
    logic       start = 1'b0;
    logic [3:0] ldone = '0;
    logic [1:0] sel;
    logic [3:0] cs;
    logic       grant, busy, dn;
    logic [9:0] cycles;

    // Zero-drain instance
    logic       start0 = 1'b0;
    logic [3:0] ld0 = '0;
    logic [1:0] sel0;
    logic [3:0] cs0;
    logic       grant0, busy0, dn0;
    logic [9:0] cycles0;

    // Saturating-timer instance: TIMER_SIZE=4
    logic       startS = 1'b0;
    logic [3:0] ldS = '0;
    logic [1:0] selS;
    logic [3:0] csS;
    logic       grantS, busyS, dnS;
    logic [3:0] cyclesS;

    int n_pass = 0;
    int n_fail = 0;
    int n_chk  = 0;

    logic [3:0] exp_cs_q[$];
    int         exp_cyc_q[$];

    fft_layer_sequencer #(.NUM_LAYERS(4), .DRAIN_CYCLES(2), .TIMER_SIZE(10)) u_dut (
        .i_CLK(clk), .i_RST(rst), .i_start(start), .i_layer_done(ldone),
        .o_layer_sel(sel), .o_cs(cs), .o_bus_grant(grant), .o_busy(busy),
        .o_done(dn), .o_cycles(cycles));

    fft_layer_sequencer #(.NUM_LAYERS(4), .DRAIN_CYCLES(0), .TIMER_SIZE(10)) u_dut0 (
        .i_CLK(clk), .i_RST(rst), .i_start(start0), .i_layer_done(ld0),
        .o_layer_sel(sel0), .o_cs(cs0), .o_bus_grant(grant0), .o_busy(busy0),
        .o_done(dn0), .o_cycles(cycles0));

    fft_layer_sequencer #(.NUM_LAYERS(4), .DRAIN_CYCLES(2), .TIMER_SIZE(4)) u_sat (
        .i_CLK(clk), .i_RST(rst), .i_start(startS), .i_layer_done(ldS),
        .o_layer_sel(selS), .o_cs(csS), .o_bus_grant(grantS), .o_busy(busyS),
        .o_done(dnS), .o_cycles(cyclesS));

    initial forever #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: per-cycle chip-select trace while busy, cycle count at each done pulse.
    always @(negedge clk) begin : mon
        logic [3:0] e;
        if (busy && exp_cs_q.size() > 0) begin
            e = exp_cs_q.pop_front();
            check("cs_trace", 32'(cs), 32'(e));
            check("grant_trace", 32'(grant), 32'(e != 4'd0));
        end
        if (dn) begin
            if (exp_cyc_q.size() > 0) check("cycles_at_done", 32'(cycles), 32'(exp_cyc_q.pop_front()));
            else check("unexpected_done", 32'(dn), 32'd0);
        end
    end

    // Drives one transform on the main instance; done is raised in RUN cycle runlen of each layer.
    task automatic run_main(input int runlen, input bit spur, input bit abort);
        int rc = 0;
        int busy_cnt = 0;
        int ndone = 0;
        bit stop = 1'b0;
        for (int l = 0; l < 4; l++) begin
            repeat (runlen) exp_cs_q.push_back(4'(1 << l));
            repeat (2) exp_cs_q.push_back(4'd0);
        end
        exp_cs_q.push_back(4'd0);
        exp_cyc_q.push_back(4 * (runlen + 2));
        start = 1'b1;
        for (int t = 0; t < 400 && !stop; t++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy) busy_cnt++;
            if (dn) begin
                ndone++;
                stop = 1'b1;
            end
            if (abort && busy && !grant && sel == 2'd2) stop = 1'b1;
            rc = grant ? rc + 1 : 0;
            if (spur && grant && sel == 2'd1 && rc == 2) start = 1'b1;
            if (grant && rc == runlen)         ldone = 4'(1 << sel);
            else if (spur && grant && sel == 0) ldone = 4'b1110;
            else                               ldone = 4'b0000;
        end
        ldone = '0;
        start = 1'b0;
        if (!abort) begin
            check("done_pulses", 32'(ndone), 32'd1);
            check("busy_span", 32'(busy_cnt), 32'(4 * (runlen + 2) + 1));
        end
    endtask

    initial begin
        // Asynchronous reset, asserted between clock edges
        #2 rst = 1'b1;
        #1;
        check("reset_main", 32'({sel, cs, grant, busy, dn, cycles}), 32'd0);
        check("reset_zero", 32'({sel0, cs0, grant0, busy0, dn0, cycles0}), 32'd0);
        check("reset_sat", 32'({selS, csS, grantS, busyS, dnS, cyclesS}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_quiet", 32'({sel, cs, grant, busy, dn, cycles}), 32'd0);
        end

        // Nominal transform
        @(negedge clk);
        run_main(5, 1'b0, 1'b0);
        @(negedge clk);
        check("hold_cycles", 32'(cycles), 32'd28);
        check("idle_after", 32'({busy, dn, cs}), 32'd0);

        // Spurious dones on layer 0 and a start request during RUN
        run_main(5, 1'b1, 1'b0);
        @(negedge clk);
        check("spur_hold_cycles", 32'(cycles), 32'd28);

        // Reset during layer-2 drain
        run_main(5, 1'b0, 1'b1);
        check("abort_in_drain", 32'({busy, grant, sel}), 32'({1'b1, 1'b0, 2'd2}));
        check("abort_mid_cycles", 32'(cycles), 32'd19);
        exp_cs_q.delete();
        exp_cyc_q.delete();
        rst = 1'b1;
        #1;
        check("abort_reset", 32'({sel, cs, grant, busy, dn, cycles}), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_no_done", 32'(dn), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        run_main(5, 1'b0, 1'b0);
        @(negedge clk);
        check("restart_cycles", 32'(cycles), 32'd28);

        // Zero drain: one layer per cycle, then start held across done re-triggers
        start0 = 1'b1;
        ld0    = 4'hF;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("zd_sel", 32'(sel0), 32'(i));
            check("zd_cs", 32'(cs0), 32'(1 << i));
        end
        @(negedge clk);
        check("zd_done", 32'({dn0, busy0, cs0}), 32'({1'b1, 1'b1, 4'd0}));
        check("zd_cycles", 32'(cycles0), 32'd4);
        @(negedge clk);
        check("zd_idle", 32'({busy0, dn0}), 32'd0);
        check("zd_idle_hold", 32'(cycles0), 32'd4);
        @(negedge clk);
        start0 = 1'b0;
        check("zd_retrigger", 32'({grant0, sel0}), 32'({1'b1, 2'd0}));
        check("zd_retrig_clear", 32'(cycles0), 32'd0);
        repeat (4) @(negedge clk);
        check("zd_done2", 32'(dn0), 32'd1);
        check("zd_cycles2", 32'(cycles0), 32'd4);
        ld0 = '0;

        // Saturation: layer 1 stalls with layer 0's flag still high
        startS = 1'b1;
        @(negedge clk);
        startS = 1'b0;
        ldS    = 4'b0001;
        for (int t = 0; t < 10 && !(grantS && selS == 2'd1); t++) @(negedge clk);
        check("sat_reach_l1", 32'({grantS, selS}), 32'({1'b1, 2'd1}));
        repeat (30) @(negedge clk);
        check("sat_stall", 32'({grantS, selS}), 32'({1'b1, 2'd1}));
        check("sat_value", 32'(cyclesS), 32'd15);
        ldS = 4'hF;
        for (int t = 0; t < 40 && !dnS; t++) @(negedge clk);
        check("sat_done_seen", 32'(dnS), 32'd1);
        check("sat_cycles_done", 32'(cyclesS), 32'd15);
        ldS = '0;

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
